// File: rtl/dma_src_reader_pkg.sv
// Shared DMA definitions: AHB-Lite transfer codes, fixed attributes, FSM
// state encoding and the per-word address step. The destination-side
// writer imports the same package.
package dma_src_reader_pkg;

  // AHB-Lite HTRANS codes used by single-beat masters
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Fixed transfer attributes: 32-bit word, single beat, non-cacheable data
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  // Byte increment between consecutive 32-bit words
  localparam int unsigned WORD_BYTES = 32'd4;

  // Engine state encoding
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_PUSH = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } dma_state_e;

endpackage

// File: rtl/dma_src_reader_if.sv
// AHB-Lite read-side bus bundle between the DMA source reader (master)
// and the source slave.
interface dma_src_reader_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic              HREADY;
  logic              HRESP;
  logic [31:0]       HRDATA;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/dma_src_reader.sv
// DMA source read engine: fetches len_words 32-bit words over AHB-Lite with
// single NONSEQ transfers (one outstanding at most) and pushes each word into
// the channel FIFO. One word costs ADDR + DATA + PUSH; the PUSH cycle lets
// fifo_full settle on the new write before the next ADDR decision.
module dma_src_reader
  import dma_src_reader_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clock,
  input  logic              sclr,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [LEN_W-1:0]  len_words,
  input  logic              src_inc,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  dma_src_reader_if.master  ahb,
  output logic              fifo_wrreq,
  output logic [31:0]       fifo_data,
  input  logic              fifo_full
);

  dma_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_haddr;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_inc;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_wrreq;
  logic [31:0]       r_data;

  logic              w_issue;
  logic [1:0]        w_htrans;
  logic [ADDR_W-1:0] w_next_addr;

  // An address phase is offered only in ADDR, with no abort pending and room in the FIFO
  assign w_issue = (r_state == ST_ADDR) && !abort && !fifo_full;

  // Address of the following word; the add wraps naturally at 2^ADDR_W
  always_comb begin
    w_next_addr = r_addr;
    if (r_inc) begin
      w_next_addr = r_addr + ADDR_W'(WORD_BYTES);
    end else begin
      w_next_addr = r_addr;
    end
  end

  // HTRANS is NONSEQ only while an address phase is being offered
  always_comb begin
    w_htrans = HTRANS_IDLE;
    if (w_issue) begin
      w_htrans = HTRANS_NONSEQ;
    end else begin
      w_htrans = HTRANS_IDLE;
    end
  end

  // Main FSM with its address/count datapath and registered outputs
  always_ff @(posedge clock or negedge sclr) begin
    if (!sclr) begin
      r_state <= ST_IDLE;
      r_addr  <= {ADDR_W{1'b0}};
      r_haddr <= {ADDR_W{1'b0}};
      r_cnt   <= {LEN_W{1'b0}};
      r_inc   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_wrreq <= 1'b0;
      r_data  <= 32'h0000_0000;
    end else begin
      // Pulse outputs default low; the transition that needs one sets it
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_wrreq <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr <= src_addr;
            r_cnt  <= len_words;
            r_inc  <= src_inc;
            r_busy <= 1'b1;
            if (len_words == {LEN_W{1'b0}}) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_haddr <= src_addr;
              r_state <= ST_ADDR;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (abort) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_issue && ahb.HREADY) begin
            r_state <= ST_DATA;
          end else begin
            r_state <= ST_ADDR;
          end
        end
        ST_DATA: begin
          // Abort is deliberately ignored: the beat in flight always completes
          if (ahb.HREADY) begin
            if (ahb.HRESP) begin
              r_err   <= 1'b1;
              r_state <= ST_ERR;
            end else begin
              r_data  <= ahb.HRDATA;
              r_wrreq <= 1'b1;
              r_state <= ST_PUSH;
            end
          end else begin
            r_state <= ST_DATA;
          end
        end
        ST_PUSH: begin
          r_cnt  <= r_cnt - LEN_W'(1);
          r_addr <= w_next_addr;
          if (r_cnt == LEN_W'(1)) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_haddr <= w_next_addr;
            r_state <= ST_ADDR;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_ERR: begin
          // Words not yet fetched are dropped
          r_cnt   <= {LEN_W{1'b0}};
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign fifo_wrreq = r_wrreq;
  assign fifo_data  = r_data;

  assign ahb.HADDR  = r_haddr;
  assign ahb.HTRANS = w_htrans;
  assign ahb.HWRITE = 1'b0;
  assign ahb.HSIZE  = HSIZE_WORD;
  assign ahb.HBURST = HBURST_SINGLE;
  assign ahb.HPROT  = HPROT_DATA;

endmodule

// File: doc/dma_src_reader.md
Name: dma_src_reader

Overview:
- DMA source-side read engine that sits directly upstream of the DMA channel FIFO (16x32).
- Fetches a programmed number of 32-bit words from an AHB-Lite source address and pushes each word into the FIFO write port.
- Throttles on the FIFO full flag and reports done or error to the DMA channel controller.
- Issues single (non-burst) AHB transfers with at most one outstanding transfer.

Parameters:
ADDR_W, 32, AHB address width
LEN_W, 16, transfer length counter width (words)

Ports:
clock  in  1  system clock
sclr  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; accepted only in IDLE
src_addr  in  ADDR_W  word-aligned source start address, sampled on an accepted start
len_words  in  LEN_W  number of words to fetch, sampled on an accepted start
src_inc  in  1  1: address += 4 per word; 0: fixed address (peripheral register), sampled on an accepted start
abort  in  1  level; stop at the next ADDR-state boundary
busy  out  1  high from the accepted start until DONE or ERR is exited
done  out  1  one-cycle pulse on normal completion or abort
err  out  1  one-cycle pulse on AHB error response
HADDR  out  ADDR_W  AHB address
HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only
HWRITE  out  1  constant 0
HSIZE  out  3  constant 3'b010
HBURST  out  3  constant 3'b000
HPROT  out  4  constant 4'b0011
HREADY  in  1  AHB ready
HRESP  in  1  AHB error response
HRDATA  in  32  AHB read data
fifo_wrreq  out  1  FIFO write request, registered
fifo_data  out  32  FIFO write data, registered
fifo_full  in  1  FIFO full flag

Behaviour:
- Reset (sclr=0, asynchronous):
  - state=IDLE; HADDR=0, HTRANS=IDLE.
  - busy, done, err, fifo_wrreq = 0; fifo_data = 0.
  - Address and remaining-count registers = 0.
- State machine states: IDLE, ADDR, DATA, PUSH, DONE, ERR.
- IDLE, start=1:
  - Latch addr, cnt=len_words and inc.
  - If len_words==0, go to DONE; otherwise go to ADDR.
- ADDR:
  - If abort=1, go to DONE; no AHB transfer is issued.
  - Else if fifo_full=0, drive HTRANS=NONSEQ with HADDR=addr; when HREADY=1, go to DATA.
  - Else hold with HTRANS=IDLE.
- DATA:
  - HTRANS=IDLE.
  - HREADY=1, HRESP=0: register fifo_data<=HRDATA and fifo_wrreq<=1 (asserted during PUSH for exactly one cycle); go to PUSH.
  - HREADY=1, HRESP=1: go to ERR; no FIFO write.
  - HREADY=0: wait, including the first error cycle.
- PUSH:
  - cnt<=cnt-1; addr<=addr+4 if inc, otherwise unchanged.
  - If cnt==1, go to DONE; otherwise go to ADDR.
  - The extra cycle guarantees that fifo_full reflects this write before the next ADDR check. Only this block writes the FIFO, so a full=0 sample in ADDR guarantees space in DATA.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 for one cycle, then IDLE. The remaining count is discarded.
- busy=1 in ADDR, DATA, PUSH, DONE and ERR.
- Abort is not honoured in DATA or PUSH. An in-flight beat always completes and is pushed.
- start while busy is ignored.
- Address wrap: addr+4 wraps modulo 2^ADDR_W with no error.
- Throughput: 3 cycles per word with zero-wait-state slaves and the FIFO not full.
- HADDR holds its last value while HTRANS=IDLE.
- Reset mid-transfer: everything returns to the reset values immediately. A data phase in flight on the bus is abandoned.

Decomposition:
- Shared DMA package:
  - HTRANS codes (IDLE/NONSEQ).
  - HSIZE_WORD, HBURST_SINGLE, HPROT_DATA.
  - FSM state encoding.
  - Word byte-increment constant 4.
- No sub-module; a single FSM plus datapath registers.
- The destination-side writer reuses the package.

Test Plan:
1. Basic fetch:
   - Stimulus: start with src_addr=0x2000_0000, len_words=4, src_inc=1, zero-wait slave returning addr^0xA5A5A5A5.
   - Required response: HADDR sequence 0x20000000/04/08/0C; four fifo_wrreq pulses with matching data; done 13 cycles after start; busy low after that.
2. FIFO full stall:
   - Stimulus: len=20 into an undrained FIFO.
   - Required response: exactly 16 writes; HTRANS stays IDLE while full. Draining 4 words yields exactly 4 more writes, then done.
3. Fixed address with wait states:
   - Stimulus: src_inc=0, len=3, slave inserts 2 wait states per beat.
   - Required response: all HADDR equal to src_addr; 3 writes; 5 cycles per word.
4. Error response:
   - Stimulus: slave returns two-cycle ERROR on beat 2 of 5.
   - Required response: 1 FIFO write; err pulses once; no done; no further NONSEQ.
5. Zero length and abort:
   - Stimulus (a): len=0.
   - Required response (a): done on the cycle after start; no AHB transfer.
   - Stimulus (b): abort asserted during DATA of beat 1 of 8.
   - Required response (b): beat 1 is pushed, then done; exactly 1 write.
6. Reset mid-operation:
   - Stimulus: sclr low asynchronously during DATA.
   - Required response: outputs take the reset values at once. A following start with len=2 completes normally.
